// File: rtl/alu_wb_pkg.sv
// Shared types and constants for the ALU writeback stage.
// Holds the FSM state encoding and the CPSR flag positions.
package alu_wb_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WR_LO = 3'd1,
      WR_HI = 3'd2,
      MEM   = 3'd3,
      DONE  = 3'd4
   } state_e;

   localparam int FLAG_N = 31;
   localparam int FLAG_Z = 30;
   localparam int FLAG_C = 29;
   localparam int FLAG_V = 28;

   localparam logic [31:0] NZCV_MASK = (32'd1 << FLAG_N) | (32'd1 << FLAG_Z) |
                                       (32'd1 << FLAG_C) | (32'd1 << FLAG_V);

   // Replace only the NZCV bits of the current CPSR with those produced by the ALU.
   function automatic logic [31:0] commit_nzcv(input logic [31:0] cur, input logic [31:0] alu);
      return (cur & ~NZCV_MASK) | (alu & NZCV_MASK);
   endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// Bus between the ALU, the writeback stage, the register file and the memory stage.
// The master modport is the environment, the slave modport is the writeback stage.
interface alu_writeback_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4
);
   logic              ready_in;
   logic [DATA_W-1:0] data_in1;
   logic [DATA_W-1:0] data_in2;
   logic [DATA_W-1:0] cpsr_in;
   logic              w_in;
   logic              long_in;
   logic              s_in;
   logic [REG_AW-1:0] rd_lo;
   logic [REG_AW-1:0] rd_hi;
   logic              mem_ready;
   logic              trigger_out;
   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [DATA_W-1:0] cpsr;
   logic              mem_valid;
   logic [DATA_W-1:0] mem_data;
   logic              busy;

   modport master (
      output ready_in, data_in1, data_in2, cpsr_in, w_in, long_in, s_in, rd_lo, rd_hi, mem_ready,
      input  trigger_out, rf_we, rf_waddr, rf_wdata, cpsr, mem_valid, mem_data, busy
   );

   modport slave (
      input  ready_in, data_in1, data_in2, cpsr_in, w_in, long_in, s_in, rd_lo, rd_hi, mem_ready,
      output trigger_out, rf_we, rf_waddr, rf_wdata, cpsr, mem_valid, mem_data, busy
   );
endinterface

// File: rtl/alu_writeback_req_sync.sv
// Multi-flop synchroniser for the two-phase request coming from the ALU clock domain.
module req_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);
   logic [STAGES-1:0] r_sync;

   // Shift chain; the oldest stage is the synchronised level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/alu_writeback.sv
// Writeback stage behind the ALU: register-file writes, NZCV commit, memory forwarding,
// and a two-phase trigger back to the ALU once per result.
module alu_writeback
   import alu_wb_pkg::*;
#(
   parameter int          DATA_W      = 32,
   parameter int          REG_AW      = 4,
   parameter logic [31:0] CPSR_RESET  = 32'h0000_0000,
   parameter int          SYNC_STAGES = 2
) (
   input logic            clk,
   input logic            reset_n,
   alu_writeback_if.slave bus
);
   state_e            r_state, w_state_nxt;
   logic              w_req_s, w_pending, w_capture;
   logic              r_long;
   logic [REG_AW-1:0] r_rd_hi;
   logic [DATA_W-1:0] r_data2;

   logic              r_trigger,  w_trigger_nxt;
   logic              r_rf_we,    w_rf_we_nxt;
   logic [REG_AW-1:0] r_rf_waddr, w_rf_waddr_nxt;
   logic [DATA_W-1:0] r_rf_wdata, w_rf_wdata_nxt;
   logic [DATA_W-1:0] r_cpsr,     w_cpsr_nxt;
   logic              r_mem_valid, w_mem_valid_nxt;
   logic [DATA_W-1:0] r_mem_data, w_mem_data_nxt;
   logic              r_busy,     w_busy_nxt;

   req_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
      .clk   (clk),
      .rst_n (reset_n),
      .i_d   (bus.ready_in),
      .o_q   (w_req_s)
   );

   assign w_pending = w_req_s ^ r_trigger;
   assign w_capture = (r_state == IDLE) && w_pending;

   // State register plus the operands still needed after the capture cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_long  <= 1'b0;
         r_rd_hi <= '0;
         r_data2 <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_capture) begin
            r_long  <= bus.long_in;
            r_rd_hi <= bus.rd_hi;
            r_data2 <= bus.data_in2;
         end else begin
            r_long  <= r_long;
            r_rd_hi <= r_rd_hi;
            r_data2 <= r_data2;
         end
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = w_pending ? (bus.w_in ? WR_LO : MEM) : IDLE;
         WR_LO:   w_state_nxt = r_long ? WR_HI : DONE;
         WR_HI:   w_state_nxt = DONE;
         MEM:     w_state_nxt = bus.mem_ready ? DONE : MEM;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output decode from the upcoming state so every output leaves a flop.
   always_comb begin
      w_rf_we_nxt     = 1'b0;
      w_rf_waddr_nxt  = r_rf_waddr;
      w_rf_wdata_nxt  = r_rf_wdata;
      w_mem_valid_nxt = 1'b0;
      w_mem_data_nxt  = r_mem_data;
      w_busy_nxt      = (w_state_nxt != IDLE);
      if (w_capture && bus.s_in) begin
         w_cpsr_nxt = commit_nzcv(r_cpsr, bus.cpsr_in);
      end else begin
         w_cpsr_nxt = r_cpsr;
      end
      if (r_state == DONE) begin
         w_trigger_nxt = ~r_trigger;
      end else begin
         w_trigger_nxt = r_trigger;
      end
      case (w_state_nxt)
         WR_LO: begin
            w_rf_we_nxt    = 1'b1;
            w_rf_waddr_nxt = bus.rd_lo;
            w_rf_wdata_nxt = bus.data_in1;
         end
         WR_HI: begin
            w_rf_we_nxt    = 1'b1;
            w_rf_waddr_nxt = r_rd_hi;
            w_rf_wdata_nxt = r_data2;
         end
         MEM: begin
            w_mem_valid_nxt = 1'b1;
            if (w_capture) begin
               w_mem_data_nxt = bus.data_in1;
            end else begin
               w_mem_data_nxt = r_mem_data;
            end
         end
         default: begin
            w_rf_we_nxt = 1'b0;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_trigger   <= 1'b0;
         r_rf_we     <= 1'b0;
         r_rf_waddr  <= '0;
         r_rf_wdata  <= '0;
         r_cpsr      <= CPSR_RESET;
         r_mem_valid <= 1'b0;
         r_mem_data  <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_trigger   <= w_trigger_nxt;
         r_rf_we     <= w_rf_we_nxt;
         r_rf_waddr  <= w_rf_waddr_nxt;
         r_rf_wdata  <= w_rf_wdata_nxt;
         r_cpsr      <= w_cpsr_nxt;
         r_mem_valid <= w_mem_valid_nxt;
         r_mem_data  <= w_mem_data_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   assign bus.trigger_out = r_trigger;
   assign bus.rf_we       = r_rf_we;
   assign bus.rf_waddr    = r_rf_waddr;
   assign bus.rf_wdata    = r_rf_wdata;
   assign bus.cpsr        = r_cpsr;
   assign bus.mem_valid   = r_mem_valid;
   assign bus.mem_data    = r_mem_data;
   assign bus.busy        = r_busy;
endmodule
